// File: rtl/vend_pkg.sv
// Shared coin encodings, coin value lookup and controller state encoding
// for the vending credit controllers.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_5   = 2'b00,
    COIN_10  = 2'b01,
    COIN_25  = 2'b10,
    COIN_BAD = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCUM  = 2'b01,
    VEND   = 2'b10,
    CHANGE = 2'b11
  } state_e;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;
  localparam int VAL_25 = 25;

  // Invalid code maps to 0 so it can never add credit.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 5'(VAL_5);
      COIN_10: return 5'(VAL_10);
      COIN_25: return 5'(VAL_25);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change-coin selector: largest coin not exceeding the remainder.
// Purely combinational; coin_val is 0 when nothing is left to return.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] remain,
  output logic [1:0]   chg_coin,
  output logic [W-1:0] coin_val
);

  always_comb begin
    chg_coin = COIN_5;
    coin_val = '0;
    if (remain >= W'(VAL_25)) begin
      chg_coin = COIN_25;
      coin_val = W'(VAL_25);
    end else if (remain >= W'(VAL_10)) begin
      chg_coin = COIN_10;
      coin_val = W'(VAL_10);
    end else if (remain >= W'(VAL_5)) begin
      chg_coin = COIN_5;
      coin_val = W'(VAL_5);
    end
  end

endmodule

// File: rtl/vend_credit_fsm.sv
// Parametrised vending credit controller: coin accumulation, vend handshake,
// greedy change/refund. Define VEND_TIMEOUT_EN to enable idle auto-refund.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int PRICE          = 25,
  parameter int MAX_CREDIT     = 100,
  parameter int CREDIT_W       = 7,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend_valid,
  input  logic                vend_ready,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // state  | meaning
  // IDLE   | no credit held
  // ACCUM  | credit held, below PRICE
  // VEND   | vend_valid raised, waiting for vend_ready
  // CHANGE | ejecting change/refund coins one at a time

  localparam int SUM_W = CREDIT_W + 1;

  if (PRICE % 5 != 0 || PRICE < 5 || PRICE > MAX_CREDIT) begin : g_bad_price
    $error("vend_credit_fsm: PRICE must be a multiple of 5 in 5..MAX_CREDIT");
  end
  if ((2 ** CREDIT_W) <= MAX_CREDIT) begin : g_bad_width
    $error("vend_credit_fsm: CREDIT_W too narrow for MAX_CREDIT");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vend_credit_fsm: TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state;
  logic [CREDIT_W-1:0] remain;
  logic [CREDIT_W-1:0] remain_nxt;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_ok;
  logic                timeout_hit;
  logic                refund_hit;
  logic                vend_fire;
  logic                chg_fire;
  logic [1:0]          sel_coin;
  logic [CREDIT_W-1:0] sel_val;

  assign coin_sum  = {1'b0, credit} + SUM_W'(coin_value(coin_type));
  assign coin_ok   = (coin_type != COIN_BAD) && (coin_sum <= SUM_W'(MAX_CREDIT));
  assign refund_hit = (state == ACCUM) && (cancel || timeout_hit);
  assign vend_fire = (state == VEND) && vend_valid && vend_ready;
  assign chg_fire  = (state == CHANGE) && chg_valid && chg_ready;

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  assign timeout_hit = (state == ACCUM) && !coin_valid && (idle_cnt == '0);

  // Reloaded outside ACCUM and on every accepted coin; counts only coin-free cycles.
  always_ff @(posedge clock) begin
    if (reset || state != ACCUM || (coin_valid && coin_ok && !cancel))
      idle_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    else if (!coin_valid && idle_cnt != '0)
      idle_cnt <= idle_cnt - 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    remain_nxt = remain;
    if (vend_fire)
      remain_nxt = credit - CREDIT_W'(PRICE);
    else if (refund_hit)
      remain_nxt = credit;
    else if (chg_fire)
      remain_nxt = remain - CREDIT_W'(coin_value(chg_coin));
  end

  // Selection runs on the next remainder so chg_coin can be registered.
  vend_change_sel #(.W(CREDIT_W)) u_change_sel (
    .remain   (remain_nxt),
    .chg_coin (sel_coin),
    .coin_val (sel_val)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      remain      <= '0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      vend_valid  <= 1'b0;
      chg_valid   <= 1'b0;
      chg_coin    <= COIN_5;
      busy        <= 1'b0;
    end else begin
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      remain      <= remain_nxt;
      case (state)
        IDLE, ACCUM: begin
          if (refund_hit) begin
            credit      <= '0;
            state       <= CHANGE;
            chg_valid   <= 1'b1;
            chg_coin    <= sel_coin;
            busy        <= 1'b1;
            coin_reject <= coin_valid;
          end else if (coin_valid) begin
            if (coin_ok) begin
              coin_accept <= 1'b1;
              credit      <= coin_sum[CREDIT_W-1:0];
              if (coin_sum >= SUM_W'(PRICE)) begin
                state      <= VEND;
                vend_valid <= 1'b1;
                busy       <= 1'b1;
              end else begin
                state <= ACCUM;
              end
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (vend_fire) begin
            vend_valid <= 1'b0;
            credit     <= '0;
            if (sel_val == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= CHANGE;
              chg_valid <= 1'b1;
              chg_coin  <= sel_coin;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (chg_fire) begin
            if (sel_val == '0) begin
              state     <= IDLE;
              chg_valid <= 1'b0;
              chg_coin  <= COIN_5;
              busy      <= 1'b0;
            end else begin
              chg_coin <= sel_coin;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
